// File: rtl/clock_ratio_meter.sv
// Measures a slow (e.g. divided) clock against clk: period and high time in clk cycles,
// plus lock (stable period) and stall (no rising edge within TIMEOUT cycles) status.
module clock_ratio_meter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_clk,
    input  logic             en,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             stalled
);

    localparam int unsigned MATCH_W = $clog2(LOCK_CNT);
    localparam logic [CNT_W-1:0]   TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_CNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise_c;
    logic                   timeout_c;

    logic [CNT_W-1:0]   per_cnt, per_cnt_nxt;
    logic [CNT_W-1:0]   hi_cnt, hi_cnt_nxt;
    logic [CNT_W-1:0]   period_nxt, high_time_nxt;
    logic               valid_nxt, locked_nxt, stalled_nxt;
    logic [MATCH_W-1:0] match, match_nxt;
    logic               have_prev, have_prev_nxt;

    // Synchronizer chain plus one extra flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_clk};
            s_d    <= s;
        end
    end

    assign s         = sync_q[SYNC_STAGES-1];
    assign rise_c    = s & ~s_d;
    assign timeout_c = (per_cnt == TIMEOUT_V) & ~rise_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; EN low forces IDLE from anywhere
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARM;
                ARM:     if (rise_c) state_nxt = MEAS;
                MEAS:    if (timeout_c) state_nxt = ARM;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counter, measurement and status next values
    always_comb begin
        per_cnt_nxt   = per_cnt;
        hi_cnt_nxt    = hi_cnt;
        period_nxt    = period;
        high_time_nxt = high_time;
        valid_nxt     = 1'b0;
        locked_nxt    = locked;
        stalled_nxt   = stalled;
        match_nxt     = match;
        have_prev_nxt = have_prev;

        if (!en) begin
            per_cnt_nxt   = '0;
            hi_cnt_nxt    = '0;
            locked_nxt    = 1'b0;
            stalled_nxt   = 1'b0;
            match_nxt     = '0;
            have_prev_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    per_cnt_nxt   = '0;
                    hi_cnt_nxt    = '0;
                    have_prev_nxt = 1'b0;
                end
                ARM: begin
                    // The span before the first rise is partial, so it only restarts counting
                    have_prev_nxt = 1'b0;
                    if (rise_c) begin
                        per_cnt_nxt = CNT_W'(1);
                        hi_cnt_nxt  = CNT_W'(1);
                    end
                end
                MEAS: begin
                    if (rise_c) begin
                        per_cnt_nxt   = CNT_W'(1);
                        hi_cnt_nxt    = CNT_W'(1);
                        period_nxt    = per_cnt;
                        high_time_nxt = hi_cnt;
                        valid_nxt     = 1'b1;
                        stalled_nxt   = 1'b0;
                        have_prev_nxt = 1'b1;
                        if (have_prev && (per_cnt == period)) begin
                            match_nxt  = (match == MATCH_MAX) ? match : match + MATCH_W'(1);
                            locked_nxt = (match_nxt == MATCH_MAX);
                        end else begin
                            match_nxt  = '0;
                            locked_nxt = 1'b0;
                        end
                    end else begin
                        per_cnt_nxt = per_cnt + CNT_W'(1);
                        if (s) begin
                            hi_cnt_nxt = hi_cnt + CNT_W'(1);
                        end
                        if (timeout_c) begin
                            stalled_nxt = 1'b1;
                            locked_nxt  = 1'b0;
                            match_nxt   = '0;
                        end
                    end
                end
                default: begin
                    per_cnt_nxt = '0;
                    hi_cnt_nxt  = '0;
                end
            endcase
        end
    end

    // Registered counters and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_cnt   <= '0;
            hi_cnt    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            stalled   <= 1'b0;
            match     <= '0;
            have_prev <= 1'b0;
        end else begin
            per_cnt   <= per_cnt_nxt;
            hi_cnt    <= hi_cnt_nxt;
            period    <= period_nxt;
            high_time <= high_time_nxt;
            valid     <= valid_nxt;
            locked    <= locked_nxt;
            stalled   <= stalled_nxt;
            match     <= match_nxt;
            have_prev <= have_prev_nxt;
        end
    end

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Directed bench for clock_ratio_meter: lock, ratio change, stall, reset, enable drop and
// duty-cycle/timeout-race scenarios with hand-computed expectations.
module tb_clock_ratio_meter;

    localparam int unsigned CNT_W = 16;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             in_clk = 1'b0;
    logic             en     = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             locked;
    logic             stalled;

    int ncomp      = 0;
    int nfail      = 0;
    int nvalid     = 0;
    int it         = 0;
    int stall_iter = -1;
    int v0         = 0;

    logic [CNT_W-1:0] lp = '0;
    logic [CNT_W-1:0] lh = '0;
    logic             ll = 1'b0;
    logic             lst = 1'b0;

    clock_ratio_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (1000),
        .LOCK_CNT   (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_clk   (in_clk),
        .en       (en),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .locked   (locked),
        .stalled  (stalled)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Record each VALID pulse and the first cycle STALLED is seen
    task automatic sample();
        if (valid === 1'b1) begin
            nvalid++;
            lp  = period;
            lh  = high_time;
            ll  = locked;
            lst = stalled;
        end
        if (stalled === 1'b1 && stall_iter < 0) stall_iter = it;
    endtask

    // One IN_CLK period: hi cycles high then lo cycles low, driven at negedges
    task automatic drive(input int hi, input int lo);
        it = 0;
        for (int i = 0; i < hi + lo; i++) begin
            @(negedge clk);
            sample();
            in_clk = (i < hi);
            it++;
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        #50;
        chk("rst_period", period, 0);
        chk("rst_high_time", high_time, 0);
        chk("rst_valid", valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_stalled", stalled, 0);
        #59 rst = 1'b1;
        @(negedge clk);
        en = 1'b1;
        drive(0, 4);

        // Divide-by-8
        v0 = nvalid;
        drive(4, 4);
        chk("d8_first_rise_no_valid", nvalid - v0, 0);
        drive(4, 4);
        chk("d8_v1_period", lp, 8);
        chk("d8_v1_high", lh, 4);
        chk("d8_v1_locked", ll, 0);
        drive(4, 4);
        drive(4, 4);
        chk("d8_v3_locked", ll, 0);
        drive(4, 4);
        chk("d8_v4_locked", ll, 1);
        chk("d8_v4_period", lp, 8);
        chk("d8_valid_count", nvalid - v0, 4);

        // Ratio change to divide-by-6
        drive(3, 3);
        chk("r6_last8_locked", ll, 1);
        drive(3, 3);
        chk("r6_v1_period", lp, 6);
        chk("r6_v1_high", lh, 3);
        chk("r6_v1_locked", ll, 0);
        drive(3, 3);
        drive(3, 3);
        chk("r6_v3_locked", ll, 0);
        drive(3, 3);
        chk("r6_v4_locked", ll, 1);
        chk("r6_v4_period", lp, 6);

        // Stall after a rise
        stall_iter = -1;
        v0 = nvalid;
        drive(3, 1010);
        chk("stall_cycle", stall_iter, 1003);
        chk("stall_flag", stalled, 1);
        chk("stall_locked", locked, 0);
        chk("stall_period_held", period, 6);
        chk("stall_valid_count", nvalid - v0, 1);

        // Restart at divide-by-8
        v0 = nvalid;
        drive(4, 4);
        chk("restart_no_valid", nvalid - v0, 0);
        chk("restart_still_stalled", stalled, 1);
        drive(4, 4);
        chk("restart_period", lp, 8);
        chk("restart_high", lh, 4);
        chk("restart_stall_clear", lst, 0);
        drive(4, 4);
        drive(4, 4);
        drive(4, 4);
        chk("relock_8", ll, 1);

        // Asynchronous reset mid-period
        drive(2, 0);
        #5 rst = 1'b0;
        #1;
        chk("arst_period", period, 0);
        chk("arst_high_time", high_time, 0);
        chk("arst_locked", locked, 0);
        chk("arst_stalled", stalled, 0);
        chk("arst_valid", valid, 0);
        in_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 4);
        v0 = nvalid;
        drive(4, 4);
        chk("arst_first_rise_no_valid", nvalid - v0, 0);
        drive(4, 4);
        chk("arst_second_rise_valid", nvalid - v0, 1);
        chk("arst_period_8", lp, 8);
        drive(4, 4);
        drive(4, 4);
        drive(4, 4);
        chk("en_pre_locked", ll, 1);

        // Enable dropped for 20 cycles
        en = 1'b0;
        @(negedge clk);
        chk("en_off_locked", locked, 0);
        chk("en_off_period_held", period, 8);
        chk("en_off_high_held", high_time, 4);
        v0 = nvalid;
        drive(4, 4);
        drive(4, 4);
        drive(0, 3);
        chk("en_off_no_valid", nvalid - v0, 0);
        en = 1'b1;
        drive(0, 2);
        drive(4, 4);
        chk("en_on_first_rise_no_valid", nvalid - v0, 0);
        drive(4, 4);
        chk("en_on_second_rise_valid", nvalid - v0, 1);
        chk("en_on_period", lp, 8);

        // Narrow duty cycle
        drive(1, 9);
        drive(1, 9);
        chk("duty_period", lp, 10);
        chk("duty_high", lh, 1);

        // Period equal to TIMEOUT: rise wins over timeout
        stall_iter = -1;
        drive(1, 999);
        drive(1, 999);
        chk("race_period", lp, 1000);
        chk("race_high", lh, 1);
        chk("race_stalled_at_valid", lst, 0);
        chk("race_never_stalled", stall_iter, 32'hFFFF_FFFF);
        chk("race_stalled_now", stalled, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/clock_ratio_meter.md
Name: clock_ratio_meter

Overview:
- Receive-side counterpart of the team's clock divider: measures a divided (or any slow) clock against the system clock CLK.
- Reports the period and high time in CLK cycles, flags lock when the period is stable, and flags a stall when edges stop.
- Sits beside divider instances for self-check and bring-up, and feeds status registers.

Parameters:
- CNT_W, 16: width of PERIOD, HIGH_TIME and the internal counters.
- TIMEOUT, 1000: CLK cycles without a rising edge before STALLED asserts. Must be ≥ 2 and < 2^CNT_W.
- LOCK_CNT, 4: number of consecutive identical periods required for LOCKED. Must be ≥ 2.
- SYNC_STAGES, 2: synchronizer depth on IN_CLK. Must be ≥ 2.

Ports:
- CLK, in, 1: system clock; all logic on its rising edge.
- RST, in, 1: asynchronous, active-low reset.
- IN_CLK, in, 1: measured clock; treated as asynchronous to CLK.
- EN, in, 1: measurement enable.
- PERIOD, out, CNT_W: last measured rise-to-rise period, in CLK cycles.
- HIGH_TIME, out, CNT_W: CLK cycles the synchronized input was high in that period.
- VALID, out, 1: one-cycle pulse when PERIOD and HIGH_TIME update.
- LOCKED, out, 1: period stable.
- STALLED, out, 1: no rising edge for TIMEOUT cycles.

Behaviour:
- Reset (RST=0, asynchronous):
  - All outputs, synchronizer flops, counters and the match counter go to 0.
  - FSM enters IDLE.
- Synchronizer and edge detect:
  - IN_CLK passes through SYNC_STAGES flops to give s, then one more flop to give s_d.
  - rise = s & ~s_d; fall = ~s & s_d.
  - A 0→1 on IN_CLK captured at CLK edge k produces rise in cycle k+SYNC_STAGES.
- Counters:
  - On rise: per_cnt loads 1 and hi_cnt loads 1.
  - Otherwise per_cnt increments every cycle, and hi_cnt increments while s=1.
  - hi_cnt freezes from fall until the next rise.
- FSM states: IDLE, ARM, MEAS.
  - IDLE: counters held at 0. Goes to ARM the cycle after EN=1.
  - ARM: waits for rise. First rise loads the counters, goes to MEAS, and produces no VALID, because the period before the first rise is partial.
  - MEAS, on rise:
    - PERIOD <= per_cnt; HIGH_TIME <= hi_cnt; VALID=1 next cycle (registered, one cycle wide).
    - Counters then reload as above.
  - MEAS, timeout: if per_cnt == TIMEOUT and no rise in that cycle, then STALLED<=1, LOCKED<=0, match<=0, and the FSM goes to ARM.
  - A rise in the same cycle as timeout wins: it is a normal measurement with no stall.
- Lock:
  - On each measurement, compare the new PERIOD with the previously stored PERIOD.
  - Equal: match increments, saturating at LOCK_CNT-1.
  - Not equal: match<=0 and LOCKED<=0.
  - LOCKED<=1 in the same cycle VALID reports the LOCK_CNT-th consecutive identical period.
  - The first measurement after ARM is never counted as matching.
- STALLED:
  - Clears in the cycle of the next VALID.
  - While stalled, PERIOD and HIGH_TIME hold their last values.
- EN=0 in any state:
  - Next cycle the FSM is in IDLE; LOCKED, STALLED, VALID and match are cleared.
  - PERIOD and HIGH_TIME hold their last values.
  - A measurement in progress is discarded.
- Constant-high IN_CLK: no rise, so the block stalls exactly like constant-low.
- HIGH_TIME == PERIOD is legal and reported as-is.

Test Plan:
- **Divide-by-8.** CLK period 40 ns; RST low 100 ns then high; EN=1; IN_CLK synchronous divide-by-8 (4 high, 4 low).
  - -> No VALID at the first rise.
  - -> Every later VALID shows PERIOD=8, HIGH_TIME=4.
  - -> LOCKED=1 exactly with the 4th VALID (LOCK_CNT=4).
- **Ratio change.** Locked at 8, switch IN_CLK to divide-by-6 (3/3).
  - -> LOCKED=0 at the first VALID with PERIOD≠8.
  - -> PERIOD=6, HIGH_TIME=3 thereafter.
  - -> LOCKED=1 again at the 4th consecutive PERIOD=6.
- **Stall.** Hold IN_CLK low after a rise.
  - -> STALLED=1 and LOCKED=0 when per_cnt reaches 1000.
  - -> Restart toggling at divide-by-8: no VALID at the first rise; STALLED clears with the next VALID (PERIOD=8).
- **Reset mid-period.** Assert RST asynchronously mid-period while locked.
  - -> All outputs 0 immediately, without waiting for a CLK edge.
  - -> After release, no VALID until the second rise.
- **EN drop.** Drop EN for 20 cycles while locked at period 8.
  - -> Next cycle: LOCKED=0, PERIOD=8 held, no VALID while EN=0.
  - -> Re-enable: the first VALID is at the second rise.
- **Duty cycle and timeout race.** IN_CLK 1 high, 9 low -> PERIOD=10, HIGH_TIME=1. Then use period = TIMEOUT exactly -> a normal VALID with PERIOD=1000 and STALLED stays 0.
